warp_dispatcher: RTL and testbench
==================================

# warp_dispatcher

Sits between the warp scheduler and the SIMD cores. Accepts kernel descriptors over a valid/ready handshake, allocates the lowest free warp ID, and issues each warp to an idle SIMD core chosen round-robin. Tracks per-core ownership and retires finished warps one per cycle, reporting each freed warp ID back upstream.

## Interface
- NUM_SIMD_CORES, 4: cores served; LOG2_SIMD_CORES = log2 of it.
- NUM_WARP_IDS, 15: allocatable IDs 0..14.
- LOG2_THREAD_COUNT, 3: thread-count field width.
- INVALID_WARP_ID, 4'hF: "no warp" encoding.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- kern_valid  in  1  descriptor offered.
- kern_ready  out  1  descriptor accepted this cycle if kern_valid.
- kern_thread_count  in  LOG2_THREAD_COUNT  threads in warp.
- kern_start_pc  in  32  warp start PC.
- issue_valid  out  NUM_SIMD_CORES  one-hot, 1-cycle pulse to target core.
- issue_warp_id  out  4  warp ID being issued.
- issue_start_pc  out  32  PC being issued.
- issue_thread_count  out  LOG2_THREAD_COUNT  thread count being issued.
- core_done  in  NUM_SIMD_CORES  per-core 1-cycle pulse: warp finished.
- finished_warp_id  out  4  retired ID this cycle, else INVALID_WARP_ID.
- active_warps  out  4  count of allocated IDs.

## Operation
- Dispatch FSM, two states. IDLE: kern_ready = IDLE && any free ID && any FREE core. On accept with thread_count != 0, latch the descriptor, allocated ID and selected core, then go to ISSUE. ISSUE: drive issue_* for one cycle, then return to IDLE. thread_count == 0 is accepted and discarded: no ID, no issue, stays IDLE.
- Per-core state: FREE, RUNNING or RETIRING. Latching marks the selected core RUNNING and sets its ID bit in the used mask immediately.
- core_done[c] moves core c from RUNNING to RETIRING. It is ignored in FREE or RETIRING.
- Retire arbiter: each cycle, the lowest-index RETIRING core goes to FREE. Its ID bit is cleared, and finished_warp_id is registered with that ID for one cycle.
- ID allocation picks the lowest-index clear bit of the used mask.
- Core select: the first FREE core scanning from rr_ptr upward with wrap. After a latch, rr_ptr = selected + 1 mod NUM_SIMD_CORES.
- active_warps = popcount(used mask), registered. Increments on latch and decrements on retire; the same cycle nets to no change.
- Simultaneous events: accept decisions use registered state from the start of the cycle. An ID or core freed in cycle N is allocatable from cycle N+1. core_done on a core that is latching in the same cycle cannot occur, because that core is not RUNNING yet.
- Reset mid-operation: all cores go to FREE, the mask clears, the latched descriptor is dropped, and no issue pulse is generated.

## Timing
- Reset values: kern_ready 0 while rst is high; issue_valid 0; issue_warp_id INVALID_WARP_ID; issue_start_pc 0; issue_thread_count 0; finished_warp_id INVALID_WARP_ID; active_warps 0; rr_ptr 0; FSM in IDLE. kern_ready rises in the first cycle after rst falls.
- Accept at edge N gives issue_valid high in cycle N+1 for exactly one cycle. Peak throughput is 1 warp per 2 cycles.
- core_done at edge N makes the core RETIRING. If that core is the lowest RETIRING core, finished_warp_id is valid in cycle N+1 and the core is FREE from N+1.
- k simultaneous core_done pulses retire over k consecutive cycles in ascending core index.
- When all 15 IDs or all cores are in use, kern_ready holds 0 and descriptor inputs must stay stable (standard valid/ready).

## Structure
- Shared package (Structs_and_Params.svh) holds:
  - NUM_SIMD_CORES, LOG2_SIMD_CORES, LOG2_THREAD_COUNT, NUM_WARP_IDS, INVALID_WARP_ID;
  - core_state_t enum;
  - kernel_t (used for the latched descriptor).
- Sub-module warp_id_allocator owns the 15-bit used mask:
  - inputs: alloc, free_en, free_id;
  - outputs: alloc_id, any_free, popcount;
  - behaviour: lowest-free priority encode.

## Test plan
- Reset, then one descriptor (pc 0x100, 4 threads) -> issue_valid 4'b0001 one cycle later, warp ID 0, active_warps 1; core_done[0] -> finished_warp_id 0 next cycle, active_warps 0.
- Four back-to-back descriptors -> issued to cores 0, 1, 2, 3 with IDs 0, 1, 2, 3 on alternate cycles; a fifth is held with kern_ready 0 until any core_done.
- core_done 4'b1010 in the same cycle -> finished_warp_id 1 then 3 on consecutive cycles; kern_ready reasserts one cycle after the first retire.
- Free warp ID 2 while 0, 1 and 3 stay busy -> the next descriptor receives ID 2; rr_ptr continues from the last issued core.
- Descriptor with thread_count 0 -> accepted, no issue_valid, active_warps unchanged; core_done to a FREE core is ignored.
- Assert rst during the ISSUE state -> no issue pulse, all outputs at reset values, next descriptor receives ID 0 on core 0.

Source files
------------

// File: rtl/warp_dispatcher_pkg.sv
// Shared parameters and types for the warp dispatcher and its ID allocator.
// Core count must stay a power of two so the round-robin index wraps by truncation.
package warp_dispatcher_pkg;

  localparam int NUM_SIMD_CORES    = 4;
  localparam int LOG2_SIMD_CORES   = $clog2(NUM_SIMD_CORES);
  localparam int NUM_WARP_IDS      = 15;
  localparam int WARP_ID_W         = 4;
  localparam int LOG2_THREAD_COUNT = 3;
  localparam logic [WARP_ID_W-1:0] INVALID_WARP_ID = 4'hF;

  typedef enum logic [1:0] {
    CORE_FREE,
    CORE_RUNNING,
    CORE_RETIRING
  } core_state_t;

  typedef enum logic {
    DS_IDLE,
    DS_ISSUE
  } dispatch_state_t;

  typedef struct packed {
    logic [31:0]                  start_pc;
    logic [LOG2_THREAD_COUNT-1:0] thread_count;
    logic [WARP_ID_W-1:0]         warp_id;
  } kernel_t;

  function automatic logic [NUM_SIMD_CORES-1:0] core_onehot(
    input logic [LOG2_SIMD_CORES-1:0] idx
  );
    logic [NUM_SIMD_CORES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/warp_id_allocator.sv
// Owns the warp-ID used mask: hands out the lowest clear ID and keeps a live count.
module warp_id_allocator
  import warp_dispatcher_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc,
  input  logic                 free_en,
  input  logic [WARP_ID_W-1:0] free_id,
  output logic [WARP_ID_W-1:0] alloc_id,
  output logic                 any_free,
  output logic [WARP_ID_W-1:0] popcount
);

  logic [NUM_WARP_IDS-1:0] used_q;
  logic [NUM_WARP_IDS-1:0] set_mask;
  logic [NUM_WARP_IDS-1:0] clr_mask;
  logic [WARP_ID_W-1:0]    count_q;

  always_comb begin
    alloc_id = INVALID_WARP_ID;
    any_free = ~&used_q;
    for (int i = NUM_WARP_IDS - 1; i >= 0; i--) begin
      if (!used_q[i]) alloc_id = WARP_ID_W'(i);
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_WARP_IDS; i++) begin
      set_mask[i] = alloc   && (alloc_id == WARP_ID_W'(i));
      clr_mask[i] = free_en && (free_id  == WARP_ID_W'(i));
    end
  end

  // The freed ID is still marked used this cycle, so set and clear never hit the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used_q  <= '0;
      count_q <= '0;
    end else begin
      used_q <= (used_q | set_mask) & ~clr_mask;
      case ({alloc, free_en})
        2'b10:   count_q <= count_q + WARP_ID_W'(1);
        2'b01:   count_q <= count_q - WARP_ID_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign popcount = count_q;

endmodule

// File: rtl/warp_dispatcher.sv
// Accepts kernel descriptors, allocates warp IDs, issues round-robin to idle SIMD
// cores and retires finished warps one per cycle.
module warp_dispatcher
  import warp_dispatcher_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         kern_valid,
  output logic                         kern_ready,
  input  logic [LOG2_THREAD_COUNT-1:0] kern_thread_count,
  input  logic [31:0]                  kern_start_pc,
  output logic [NUM_SIMD_CORES-1:0]    issue_valid,
  output logic [WARP_ID_W-1:0]         issue_warp_id,
  output logic [31:0]                  issue_start_pc,
  output logic [LOG2_THREAD_COUNT-1:0] issue_thread_count,
  input  logic [NUM_SIMD_CORES-1:0]    core_done,
  output logic [WARP_ID_W-1:0]         finished_warp_id,
  output logic [WARP_ID_W-1:0]         active_warps
);

  dispatch_state_t             state_q;
  core_state_t                 core_state_q [NUM_SIMD_CORES];
  logic [WARP_ID_W-1:0]        core_warp_q  [NUM_SIMD_CORES];
  logic [LOG2_SIMD_CORES-1:0]  rr_ptr_q;
  logic [LOG2_SIMD_CORES-1:0]  sel_core;
  logic [LOG2_SIMD_CORES-1:0]  scan_idx;
  logic [LOG2_SIMD_CORES-1:0]  ret_core;
  logic                        any_core_free;
  logic                        id_free;
  logic                        accept;
  logic                        latch;
  logic                        ret_en;
  logic [WARP_ID_W-1:0]        alloc_id;
  logic [WARP_ID_W-1:0]        free_id;
  logic [WARP_ID_W-1:0]        finished_q;
  logic [NUM_SIMD_CORES-1:0]   issue_valid_q;
  kernel_t                     kern_q;

  warp_id_allocator u_alloc (
    .clk      (clk),
    .rst      (rst),
    .alloc    (latch),
    .free_en  (ret_en),
    .free_id  (free_id),
    .alloc_id (alloc_id),
    .any_free (id_free),
    .popcount (active_warps)
  );

  // Descending scan so the first FREE core at or after rr_ptr wins.
  always_comb begin
    any_core_free = 1'b0;
    sel_core      = rr_ptr_q;
    scan_idx      = '0;
    for (int i = NUM_SIMD_CORES - 1; i >= 0; i--) begin
      scan_idx = rr_ptr_q + LOG2_SIMD_CORES'(i);
      if (core_state_q[scan_idx] == CORE_FREE) begin
        any_core_free = 1'b1;
        sel_core      = scan_idx;
      end
    end
  end

  // A done pulse on a RUNNING core competes for retirement in the same cycle.
  always_comb begin
    ret_en   = 1'b0;
    ret_core = '0;
    for (int c = NUM_SIMD_CORES - 1; c >= 0; c--) begin
      if (core_state_q[c] == CORE_RETIRING ||
          (core_state_q[c] == CORE_RUNNING && core_done[c])) begin
        ret_en   = 1'b1;
        ret_core = LOG2_SIMD_CORES'(c);
      end
    end
  end

  assign free_id    = core_warp_q[ret_core];
  assign kern_ready = !rst && (state_q == DS_IDLE) && id_free && any_core_free;
  assign accept     = kern_valid && kern_ready;
  assign latch      = accept && (kern_thread_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_SIMD_CORES; c++) core_state_q[c] <= CORE_FREE;
      rr_ptr_q   <= '0;
      finished_q <= INVALID_WARP_ID;
    end else begin
      for (int c = 0; c < NUM_SIMD_CORES; c++) begin
        if (ret_en && ret_core == LOG2_SIMD_CORES'(c))
          core_state_q[c] <= CORE_FREE;
        else if (core_state_q[c] == CORE_RUNNING && core_done[c])
          core_state_q[c] <= CORE_RETIRING;
      end
      if (latch) begin
        core_state_q[sel_core] <= CORE_RUNNING;
        rr_ptr_q               <= sel_core + LOG2_SIMD_CORES'(1);
      end
      finished_q <= ret_en ? free_id : INVALID_WARP_ID;
    end
  end

  // Ownership is only read for cores that have left FREE, so it needs no reset.
  always_ff @(posedge clk) begin
    if (latch) core_warp_q[sel_core] <= alloc_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= DS_IDLE;
      issue_valid_q <= '0;
      kern_q        <= '{start_pc: 32'h0, thread_count: '0, warp_id: INVALID_WARP_ID};
    end else begin
      case (state_q)
        DS_IDLE: begin
          issue_valid_q <= '0;
          if (latch) begin
            kern_q        <= '{start_pc: kern_start_pc, thread_count: kern_thread_count,
                               warp_id: alloc_id};
            issue_valid_q <= core_onehot(sel_core);
            state_q       <= DS_ISSUE;
          end
        end
        DS_ISSUE: begin
          issue_valid_q <= '0;
          state_q       <= DS_IDLE;
        end
        default: begin
          issue_valid_q <= '0;
          state_q       <= DS_IDLE;
        end
      endcase
    end
  end

  assign issue_valid        = issue_valid_q;
  assign issue_warp_id      = kern_q.warp_id;
  assign issue_start_pc     = kern_q.start_pc;
  assign issue_thread_count = kern_q.thread_count;
  assign finished_warp_id   = finished_q;

endmodule

// File: tb/tb_warp_dispatcher.sv
// Scoreboard bench for warp_dispatcher: expected issues and retirements are queued
// when stimulus is driven and matched by a monitor as the DUT produces them.
`timescale 1ns/1ps
module tb_warp_dispatcher;
  import warp_dispatcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kern_valid = 1'b0;
  logic        kern_ready;
  logic [2:0]  kern_thread_count = '0;
  logic [31:0] kern_start_pc = '0;
  logic [3:0]  issue_valid;
  logic [3:0]  issue_warp_id;
  logic [31:0] issue_start_pc;
  logic [2:0]  issue_thread_count;
  logic [3:0]  core_done = '0;
  logic [3:0]  finished_warp_id;
  logic [3:0]  active_warps;

  typedef struct {
    int          cyc;
    logic [3:0]  valid;
    logic [3:0]  id;
    logic [31:0] pc;
    logic [2:0]  tc;
  } issue_exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] id;
  } fin_exp_t;

  issue_exp_t iq[$];
  fin_exp_t   fq[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  warp_dispatcher dut (
    .clk                (clk),
    .rst                (rst),
    .kern_valid         (kern_valid),
    .kern_ready         (kern_ready),
    .kern_thread_count  (kern_thread_count),
    .kern_start_pc      (kern_start_pc),
    .issue_valid        (issue_valid),
    .issue_warp_id      (issue_warp_id),
    .issue_start_pc     (issue_start_pc),
    .issue_thread_count (issue_thread_count),
    .core_done          (core_done),
    .finished_warp_id   (finished_warp_id),
    .active_warps       (active_warps)
  );

  // Monitor samples 2ns after each edge; the driver acts 4ns after each edge.
  always @(posedge clk) begin
    issue_exp_t ie;
    fin_exp_t   fe;
    #2;
    cyc++;
    if (issue_valid !== 4'b0000) begin
      checks++;
      if (iq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue cyc %0d got valid=%b id=%0d", cyc, issue_valid, issue_warp_id);
      end else begin
        ie = iq.pop_front();
        if (ie.cyc != cyc || issue_valid !== ie.valid || issue_warp_id !== ie.id ||
            issue_start_pc !== ie.pc || issue_thread_count !== ie.tc) begin
          errors++;
          $display("FAIL issue cyc %0d got valid=%b id=%0d pc=%h tc=%0d, want cyc %0d valid=%b id=%0d pc=%h tc=%0d",
                   cyc, issue_valid, issue_warp_id, issue_start_pc, issue_thread_count,
                   ie.cyc, ie.valid, ie.id, ie.pc, ie.tc);
        end
      end
    end
    while (iq.size() > 0 && iq[0].cyc < cyc) begin
      ie = iq.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_issue got none, want id=%0d at cyc %0d", ie.id, ie.cyc);
    end
    if (finished_warp_id !== INVALID_WARP_ID) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_finish cyc %0d got id=%0d", cyc, finished_warp_id);
      end else begin
        fe = fq.pop_front();
        if (fe.cyc != cyc || finished_warp_id !== fe.id) begin
          errors++;
          $display("FAIL finish cyc %0d got id=%0d, want id=%0d at cyc %0d", cyc, finished_warp_id, fe.id, fe.cyc);
        end
      end
    end
    while (fq.size() > 0 && fq[0].cyc < cyc) begin
      fe = fq.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_finish got none, want id=%0d at cyc %0d", fe.id, fe.cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #4;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic send(input logic [31:0] pc, input logic [2:0] tc, input int exp_core, input int exp_id);
    issue_exp_t e;
    kern_valid        = 1'b1;
    kern_start_pc     = pc;
    kern_thread_count = tc;
    for (int t = 0; t < 50 && !kern_ready; t++) step();
    checks++;
    if (!kern_ready) begin
      errors++;
      $display("FAIL send_ready timeout pc=%h got kern_ready=0 want 1", pc);
    end else if (tc != 3'd0) begin
      e.cyc   = cyc + 1;
      e.valid = 4'b0001 << exp_core;
      e.id    = 4'(exp_id);
      e.pc    = pc;
      e.tc    = tc;
      iq.push_back(e);
    end
    step();
    kern_valid = 1'b0;
  endtask

  // ids holds the expected retire order, lowest nibble first.
  task automatic pulse_done(input logic [3:0] mask, input int n, input logic [15:0] ids);
    fin_exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc = cyc + 1 + k;
      e.id  = ids[4*k +: 4];
      fq.push_back(e);
    end
    core_done = mask;
    step();
    core_done = 4'b0000;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step();
    check_val("rst_kern_ready", 32'(kern_ready), 0);
    check_val("rst_issue_valid", 32'(issue_valid), 0);
    check_val("rst_issue_id", 32'(issue_warp_id), 32'hF);
    check_val("rst_issue_pc", issue_start_pc, 0);
    check_val("rst_issue_tc", 32'(issue_thread_count), 0);
    check_val("rst_finished", 32'(finished_warp_id), 32'hF);
    check_val("rst_active", 32'(active_warps), 0);
    rst = 1'b0;
    step();
    check_val("post_rst_ready", 32'(kern_ready), 1);
  endtask

  task automatic test_single();
    send(32'h100, 3'd4, 0, 0);
    check_val("single_active1", 32'(active_warps), 1);
    step();
    pulse_done(4'b0001, 1, 16'h0000);
    check_val("single_active0", 32'(active_warps), 0);
    step();
  endtask

  task automatic test_back_to_back();
    issue_exp_t e;
    apply_reset();
    send(32'h200, 3'd1, 0, 0);
    send(32'h204, 3'd2, 1, 1);
    send(32'h208, 3'd3, 2, 2);
    send(32'h20C, 3'd7, 3, 3);
    check_val("b2b_active4", 32'(active_warps), 4);
    kern_valid        = 1'b1;
    kern_start_pc     = 32'h210;
    kern_thread_count = 3'd5;
    for (int t = 0; t < 3; t++) begin
      check_val("b2b_held_ready", 32'(kern_ready), 0);
      step();
    end
    fq.push_back('{cyc: cyc + 1, id: 4'd0});
    core_done = 4'b0001;
    step();
    core_done = 4'b0000;
    check_val("b2b_ready_after_done", 32'(kern_ready), 1);
    e = '{cyc: cyc + 1, valid: 4'b0001, id: 4'd0, pc: 32'h210, tc: 3'd5};
    iq.push_back(e);
    step();
    kern_valid = 1'b0;
    step();
  endtask

  task automatic test_simultaneous_done();
    check_val("sim_ready_full", 32'(kern_ready), 0);
    pulse_done(4'b1010, 2, 16'h0031);
    check_val("sim_ready_reassert", 32'(kern_ready), 1);
    step();
    check_val("sim_active2", 32'(active_warps), 2);
  endtask

  task automatic test_id_reuse();
    send(32'h300, 3'd2, 1, 1);
    send(32'h304, 3'd2, 3, 3);
    pulse_done(4'b0100, 1, 16'h0002);
    send(32'h308, 3'd6, 2, 2);
    check_val("reuse_active4", 32'(active_warps), 4);
    step();
  endtask

  task automatic test_zero_threads();
    pulse_done(4'b1111, 4, 16'h3210);
    step();
    step();
    step();
    check_val("zero_drained", 32'(active_warps), 0);
    send(32'h400, 3'd0, 0, 0);
    check_val("zero_active", 32'(active_warps), 0);
    check_val("zero_ready", 32'(kern_ready), 1);
    step();
    pulse_done(4'b0010, 0, 16'h0000);
    step();
    check_val("free_done_active", 32'(active_warps), 0);
    send(32'h404, 3'd5, 3, 0);
    check_val("zero_next_active", 32'(active_warps), 1);
    step();
  endtask

  task automatic test_reset_mid_issue();
    kern_valid        = 1'b1;
    kern_start_pc     = 32'h777;
    kern_thread_count = 3'd2;
    check_val("rmi_ready", 32'(kern_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #3;
    kern_valid = 1'b0;
    check_val("rmi_issue_valid", 32'(issue_valid), 0);
    check_val("rmi_issue_id", 32'(issue_warp_id), 32'hF);
    check_val("rmi_issue_pc", issue_start_pc, 0);
    check_val("rmi_issue_tc", 32'(issue_thread_count), 0);
    check_val("rmi_finished", 32'(finished_warp_id), 32'hF);
    check_val("rmi_active", 32'(active_warps), 0);
    check_val("rmi_ready", 32'(kern_ready), 0);
    step();
    rst = 1'b0;
    step();
    send(32'h800, 3'd3, 0, 0);
    check_val("rmi_next_active", 32'(active_warps), 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_simultaneous_done();
    test_id_reuse();
    test_zero_threads();
    test_reset_mid_issue();
    step();
    step();
    step();
    check_val("issue_queue_empty", 32'(iq.size()), 0);
    check_val("finish_queue_empty", 32'(fq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
